// File: rtl/peridot_spi_slave.sv
// SPI mode-0 byte slave with an Avalon-MM register window (reg0 data/status, reg1 irq control).
// Optional overrun detection: define PERIDOT_SPI_SLAVE_OVERRUN_EN.
module peridot_spi_slave #(
    parameter logic [7:0] IDLE_TXDATA = 8'hFF
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    input  logic        spi_ss_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    // Synchronizer chains; the third stage of ss_n/sclk exists only for edge detection
    logic ss_meta, ss_sync, ss_d;
    logic sclk_meta, sclk_sync, sclk_d;
    logic mosi_meta, mosi_sync;

    logic [BYTE_W-1:0] tx_buf;
    logic              txready;
    logic [BYTE_W-1:0] tx_shift;
    logic [BYTE_W-1:0] rx_shift;
    logic [BYTE_W-1:0] rxdata;
    logic              rxvalid;
    logic              irqena;
    logic              overrun;
    logic [CNT_W-1:0]  bit_cnt;
    logic              byte_done;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall, byte_start, last_rise;
    logic wr_reg0, wr_reg1;
    logic unused_wdata;

    assign ss_fall    = ~ss_sync & ss_d;
    assign ss_rise    = ss_sync & ~ss_d;
    assign sclk_rise  = sclk_sync & ~sclk_d & ~ss_sync;
    assign sclk_fall  = ~sclk_sync & sclk_d & ~ss_sync;
    assign byte_start = ss_fall | (sclk_fall & byte_done);
    assign last_rise  = sclk_rise & (bit_cnt == CNT_W'(BYTE_W - 1));
    assign wr_reg0    = avs_write & ~avs_address;
    assign wr_reg1    = avs_write & avs_address;
    assign unused_wdata = ^avs_writedata;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_d      <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_d    <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            ss_meta   <= spi_ss_n;
            ss_sync   <= ss_meta;
            ss_d      <= ss_sync;
            sclk_meta <= spi_sclk;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Shift engine and TX buffer; a CPU write after a byte-start load overrides the buffer
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            tx_buf    <= '0;
            txready   <= 1'b1;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rxdata    <= '0;
        end else begin
            if (ss_rise) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                byte_done <= 1'b0;
            end else if (byte_start) begin
                tx_shift  <= txready ? IDLE_TXDATA : tx_buf;
                txready   <= 1'b1;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (sclk_fall) begin
                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            end else if (sclk_rise) begin
                rx_shift <= {rx_shift[BYTE_W-2:0], mosi_sync};
                bit_cnt  <= bit_cnt + CNT_W'(1);
                if (last_rise) begin
                    byte_done <= 1'b1;
                    rxdata    <= {rx_shift[BYTE_W-2:0], mosi_sync};
                end
            end
            if (wr_reg0) begin
                tx_buf  <= avs_writedata[BYTE_W-1:0];
                txready <= 1'b0;
            end
        end
    end

    // Status flags: clear first so a same-cycle set wins
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            rxvalid <= 1'b0;
            irqena  <= 1'b0;
        end else begin
            if (wr_reg1) begin
                irqena <= avs_writedata[15];
                if (avs_writedata[8]) rxvalid <= 1'b0;
            end
            if (last_rise && !ss_rise) rxvalid <= 1'b1;
        end
    end

`ifdef PERIDOT_SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            overrun <= 1'b0;
        end else begin
            if (wr_reg1 && avs_writedata[10]) overrun <= 1'b0;
            if (last_rise && rxvalid) overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    always_comb begin
        avs_readdata = '0;
        if (avs_read) begin
            if (!avs_address) begin
                avs_readdata = {20'd0, ~ss_sync, overrun, txready, rxvalid, rxdata};
            end else begin
                avs_readdata = {16'd0, irqena, 4'd0, overrun, 1'b0, rxvalid, 8'd0};
            end
        end
    end

    assign ins_irq     = irqena & (rxvalid | overrun);
    assign spi_miso    = tx_shift[BYTE_W-1];
    assign spi_miso_oe = ~ss_sync;

endmodule

// File: tb/tb_peridot_spi_slave.sv
// Directed bench for peridot_spi_slave: SPI master model plus register checks.
module tb_peridot_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        ins_irq;
    logic        spi_ss_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;

    int checks = 0;
    int errors = 0;

`ifdef PERIDOT_SPI_SLAVE_OVERRUN_EN
    localparam logic [31:0] OVR = 32'h400;
`else
    localparam logic [31:0] OVR = 32'h000;
`endif

    peridot_spi_slave #(.IDLE_TXDATA(8'hFF)) dut (
        .csi_clk       (clk),
        .rsi_reset_n   (rst_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .ins_irq       (ins_irq),
        .spi_ss_n      (spi_ss_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic reg_read(input logic a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        #1;
        d = avs_readdata;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    // Mode-0 master, half period 4 clocks; leaves ss_n low. Optional reg1 W1C aligned to the 8th rise.
    task automatic spi_frame(input logic [7:0] tx, input int nbits, input bit w1c_last,
                             output logic [7:0] rx);
        rx = '0;
        spi_mosi = tx[7];
        spi_ss_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            rx[7-i]  = spi_miso;
            spi_sclk = 1'b1;
            if (w1c_last && i == 7) begin
                wait_clk(2);
                avs_address   = 1'b1;
                avs_writedata = 32'h100;
                avs_write     = 1'b1;
                wait_clk(1);
                avs_write     = 1'b0;
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
            spi_sclk = 1'b0;
            if (i < 7) spi_mosi = tx[6-i];
            wait_clk(4);
        end
    endtask

    task automatic spi_end();
        spi_ss_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  rx;

        rst_n = 1'b0;
        avs_address = 1'b0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        wait_clk(3);
        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_oe", 32'(spi_miso_oe), 32'h0);
        check("rst_irq", 32'(ins_irq), 32'h0);
        reg_read(1'b0, rd); check("rst_reg0", rd, 32'h200);
        reg_read(1'b1, rd); check("rst_reg1", rd, 32'h0);
        rst_n = 1'b1;
        wait_clk(3);

        // TX byte loaded, master sends 0x3C
        reg_write(1'b0, 32'h5A);
        reg_read(1'b0, rd); check("tx_loaded_reg0", rd, 32'h000);
        spi_frame(8'h3C, 8, 1'b0, rx);
        check("miso_5a", 32'(rx), 32'h5A);
        check("oe_busy", 32'(spi_miso_oe), 32'h1);
        reg_read(1'b0, rd); check("reg0_busy", rd, 32'hB3C);
        spi_end();
        check("oe_idle", 32'(spi_miso_oe), 32'h0);
        reg_read(1'b0, rd); check("reg0_after_ss", rd, 32'h33C);
        reg_write(1'b1, 32'h100);
        reg_read(1'b0, rd); check("reg0_w1c", rd, 32'h23C);

        // Empty TX buffer sends the idle byte
        spi_frame(8'hA5, 8, 1'b0, rx);
        spi_end();
        check("miso_idle", 32'(rx), 32'hFF);
        reg_read(1'b0, rd); check("reg0_a5", rd, 32'h3A5);
        reg_write(1'b1, 32'h100);

        // Second byte without clearing rxvalid
        reg_write(1'b1, 32'h8000);
        check("irq_quiet", 32'(ins_irq), 32'h0);
        spi_frame(8'h11, 8, 1'b0, rx);
        spi_end();
        check("irq_rx1", 32'(ins_irq), 32'h1);
        spi_frame(8'h22, 8, 1'b0, rx);
        spi_end();
        reg_read(1'b0, rd); check("reg0_ovr", rd, 32'h322 | OVR);
        reg_read(1'b1, rd); check("reg1_ovr", rd, 32'h8100 | OVR);
        check("irq_ovr", 32'(ins_irq), 32'h1);
        reg_write(1'b1, 32'h0500);
        check("irq_cleared", 32'(ins_irq), 32'h0);
        reg_read(1'b1, rd); check("reg1_cleared", rd, 32'h0);

        // Aborted partial byte then a full one
        spi_frame(8'hFF, 5, 1'b0, rx);
        spi_end();
        reg_read(1'b0, rd); check("reg0_partial", rd, 32'h222);
        spi_frame(8'h81, 8, 1'b0, rx);
        spi_end();
        check("miso_81", 32'(rx), 32'hFF);
        reg_read(1'b0, rd); check("reg0_81", rd, 32'h381);

        // Reset pulse mid-byte
        reg_write(1'b1, 32'h8000);
        check("irq_pre_rst", 32'(ins_irq), 32'h1);
        reg_write(1'b0, 32'hC3);
        spi_frame(8'hF0, 3, 1'b0, rx);
        rst_n = 1'b0;
        #1;
        check("rst2_miso", 32'(spi_miso), 32'h0);
        check("rst2_oe", 32'(spi_miso_oe), 32'h0);
        check("rst2_irq", 32'(ins_irq), 32'h0);
        @(negedge clk);
        reg_read(1'b0, rd); check("rst2_reg0", rd, 32'h200);
        reg_read(1'b1, rd); check("rst2_reg1", rd, 32'h0);
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(3);
        spi_frame(8'h6E, 8, 1'b0, rx);
        spi_end();
        check("miso_post_rst", 32'(rx), 32'hFF);
        reg_read(1'b0, rd); check("reg0_post_rst", rd, 32'h36E);

        // W1C coinciding with the rxvalid set
        reg_write(1'b1, 32'h100);
        reg_read(1'b0, rd); check("reg0_pre_race", rd, 32'h26E);
        spi_frame(8'h4D, 8, 1'b1, rx);
        spi_end();
        reg_read(1'b0, rd); check("reg0_race", rd, 32'h34D);
        reg_read(1'b1, rd); check("reg1_race", rd, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
